// File: rtl/ps2_key_ctrl.sv
// PS/2 receive-FIFO consumer: pops scan codes, tracks make/break/extended
// prefixes and publishes the held key. Optional E0 handling via PS2_KEY_EXT_EN.
module ps2_key_ctrl #(
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ready,
  input  logic [7:0]       data,
  output logic             nextdata_n,
  output logic [7:0]       key_code,
  output logic             key_ext,
  output logic             key_valid,
  output logic             key_strobe,
  output logic [CNT_W-1:0] press_cnt
);

  localparam int unsigned BYTE_W = 8;
  localparam logic [BYTE_W-1:0] BRK_CODE = BYTE_W'(8'hF0);
  localparam logic [BYTE_W-1:0] EXT_CODE = BYTE_W'(8'hE0);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    POP  = 2'd1,
    PROC = 2'd2
  } state_t;

  state_t            state;
  logic [BYTE_W-1:0] byte_r;
  logic              brk_pend;
  logic              ext_pend;
  logic              same_key_c;

`ifndef PS2_KEY_EXT_EN
  assign ext_pend = 1'b0;
  assign key_ext  = 1'b0;
`endif

  // A byte naming the key already held (same extension) is a repeat or its own break
  assign same_key_c = key_valid && (byte_r == key_code) && (ext_pend == key_ext);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      nextdata_n <= 1'b1;
      byte_r     <= '0;
      brk_pend   <= 1'b0;
      key_code   <= '0;
      key_valid  <= 1'b0;
      key_strobe <= 1'b0;
      press_cnt  <= '0;
`ifdef PS2_KEY_EXT_EN
      ext_pend   <= 1'b0;
      key_ext    <= 1'b0;
`endif
    end else begin
      key_strobe <= 1'b0;
      case (state)
        IDLE: begin
          if (ready) begin
            byte_r     <= data;
            nextdata_n <= 1'b0;
            state      <= POP;
          end
        end
        // One idle cycle after the pop lets the FIFO head pointer settle
        POP: begin
          nextdata_n <= 1'b1;
          state      <= PROC;
        end
        PROC: begin
          state <= IDLE;
          if (byte_r == BRK_CODE) begin
            brk_pend <= 1'b1;
          end else if (byte_r == EXT_CODE) begin
`ifdef PS2_KEY_EXT_EN
            ext_pend <= 1'b1;
`endif
          end else if (brk_pend) begin
            if (same_key_c) begin
              key_valid <= 1'b0;
            end
            brk_pend <= 1'b0;
`ifdef PS2_KEY_EXT_EN
            ext_pend <= 1'b0;
`endif
          end else begin
            if (!same_key_c) begin
              key_code   <= byte_r;
              key_valid  <= 1'b1;
              key_strobe <= 1'b1;
              press_cnt  <= press_cnt + CNT_W'(1);
`ifdef PS2_KEY_EXT_EN
              key_ext    <= ext_pend;
`endif
            end
`ifdef PS2_KEY_EXT_EN
            ext_pend <= 1'b0;
`endif
          end
        end
        default: begin
          state      <= IDLE;
          nextdata_n <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ps2_key_ctrl.sv
// Bench for ps2_key_ctrl: FIFO model, directed vector table, randomized byte
// streams against a scan-code reference model.
module tb_ps2_key_ctrl;

`ifdef PS2_KEY_EXT_EN
  localparam bit EXT_EN = 1'b1;
`else
  localparam bit EXT_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       ready;
  logic [7:0] data;
  logic       nextdata_n;
  logic [7:0] key_code;
  logic       key_ext;
  logic       key_valid;
  logic       key_strobe;
  logic [7:0] press_cnt;

  ps2_key_ctrl #(.CNT_W(8)) dut (
    .clk(clk), .rst(rst), .ready(ready), .data(data), .nextdata_n(nextdata_n),
    .key_code(key_code), .key_ext(key_ext), .key_valid(key_valid),
    .key_strobe(key_strobe), .press_cnt(press_cnt)
  );

  always #5 clk = ~clk;

  // FIFO model: pops on a clock edge where nextdata_n is low
  logic [7:0] fifo_mem [0:1023];
  int wr_ptr = 0;
  int rd_ptr = 0;
  assign ready = (wr_ptr != rd_ptr);
  assign data  = fifo_mem[rd_ptr[9:0]];

  always @(posedge clk) begin
    if (!nextdata_n) rd_ptr <= rd_ptr + 1;
  end

  // Pulse monitor
  int n_pops = 0, n_strobes = 0, nd_dbl = 0, st_dbl = 0;
  bit prev_nd = 1'b0, prev_st = 1'b0;
  always @(negedge clk) begin
    if (!nextdata_n) n_pops++;
    if (key_strobe) n_strobes++;
    if (!nextdata_n && prev_nd) nd_dbl++;
    if (key_strobe && prev_st) st_dbl++;
    prev_nd = !nextdata_n;
    prev_st = key_strobe;
  end

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference model over whole bytes
  logic [7:0] m_code, m_cnt;
  bit m_ext, m_valid, m_brk, m_extp;
  int m_strobes;

  function automatic void model_reset();
    m_code = 8'h00; m_cnt = 8'h00; m_ext = 0; m_valid = 0;
    m_brk = 0; m_extp = 0; m_strobes = 0;
  endfunction

  function automatic void model_byte(input logic [7:0] b);
    bit same;
    same = m_valid && (b == m_code) && (m_extp == m_ext);
    if (b == 8'hF0) m_brk = 1;
    else if (b == 8'hE0) begin
      if (EXT_EN) m_extp = 1;
    end else if (m_brk) begin
      if (same) m_valid = 0;
      m_brk = 0;
      m_extp = 0;
    end else begin
      if (!same) begin
        m_code = b; m_ext = m_extp; m_valid = 1;
        m_cnt = m_cnt + 8'd1; m_strobes++;
      end
      m_extp = 0;
    end
  endfunction

  task automatic push(input logic [7:0] b);
    fifo_mem[wr_ptr[9:0]] = b;
    wr_ptr = wr_ptr + 1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic drain(input int budget);
    int c = 0;
    while (rd_ptr != wr_ptr && c < budget) begin
      @(negedge clk);
      c++;
    end
    if (rd_ptr != wr_ptr) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: %0d bytes left after %0d cycles, expected 0", wr_ptr - rd_ptr, budget);
    end
    repeat (4) @(negedge clk);
  endtask

  typedef struct {
    string       name;
    logic [63:0] bytes;
    int          n;
    logic [7:0]  code;
    bit          valid;
    bit          ext;
    logic [7:0]  cnt;
    int          strobes;
  } vec_t;

  function automatic vec_t mk(input string name, input logic [63:0] bytes, input int n,
                              input logic [7:0] code, input bit valid, input bit ext,
                              input logic [7:0] cnt, input int strobes);
    vec_t v;
    v.name = name; v.bytes = bytes; v.n = n; v.code = code; v.valid = valid;
    v.ext = ext; v.cnt = cnt; v.strobes = strobes;
    return v;
  endfunction

  vec_t vecs [11];

  initial begin
    int p0, s0;
    logic [7:0] b;
    logic [63:0] bb;

    vecs[0] = mk("make",        64'h1C, 1, 8'h1C, 1, 0, 8'd1, 1);
    vecs[1] = mk("make_break",  64'h1CF01C, 3, 8'h1C, 0, 0, 8'd1, 1);
    vecs[2] = mk("typematic_held", 64'h1C1C1CF0, 4, 8'h1C, 1, 0, 8'd1, 1);
    vecs[3] = mk("typematic_rel",  64'h1C1C1CF01C, 5, 8'h1C, 0, 0, 8'd1, 1);
    vecs[4] = mk("rollover",    64'h1C32F01C, 4, 8'h32, 1, 0, 8'd2, 2);
    vecs[5] = mk("rollover_rel", 64'h1C32F01CF032, 6, 8'h32, 0, 0, 8'd2, 2);
    vecs[6] = mk("double_f0",   64'h1CF0F01C, 4, 8'h1C, 0, 0, 8'd1, 1);
    vecs[7] = mk("ext_make",    64'hE075, 2, 8'h75, 1, EXT_EN, 8'd1, 1);
    if (EXT_EN) begin
      vecs[8]  = mk("ext_plain_brk", 64'hE075F075, 4, 8'h75, 1, 1, 8'd1, 1);
      vecs[9]  = mk("ext_full",      64'hE075F075E0F075, 7, 8'h75, 0, 1, 8'd1, 1);
      vecs[10] = mk("ext_distinct",  64'hE07575, 3, 8'h75, 1, 0, 8'd2, 2);
    end else begin
      vecs[8]  = mk("ext_plain_brk", 64'hE075F075, 4, 8'h75, 0, 0, 8'd1, 1);
      vecs[9]  = mk("ext_full",      64'hE075F075E0F075, 7, 8'h75, 0, 0, 8'd1, 1);
      vecs[10] = mk("ext_distinct",  64'hE07575, 3, 8'h75, 1, 0, 8'd1, 1);
    end

    rst = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_nextdata_n", int'(nextdata_n), 1);
    check("rst_key_code", int'(key_code), 0);
    check("rst_key_valid", int'(key_valid), 0);
    check("rst_key_ext", int'(key_ext), 0);
    check("rst_press_cnt", int'(press_cnt), 0);
    check("rst_key_strobe", int'(key_strobe), 0);
    rst = 1'b0;

    foreach (vecs[i]) begin
      do_reset();
      p0 = n_pops; s0 = n_strobes;
      bb = vecs[i].bytes;
      for (int k = vecs[i].n - 1; k >= 0; k--) begin
        b = bb[8*k +: 8];
        push(b);
      end
      drain(3 * vecs[i].n + 20);
      check({vecs[i].name, "_code"},  int'(key_code),  int'(vecs[i].code));
      check({vecs[i].name, "_valid"}, int'(key_valid), int'(vecs[i].valid));
      check({vecs[i].name, "_ext"},   int'(key_ext),   int'(vecs[i].ext));
      check({vecs[i].name, "_cnt"},   int'(press_cnt), int'(vecs[i].cnt));
      check({vecs[i].name, "_strobes"}, n_strobes - s0, vecs[i].strobes);
      check({vecs[i].name, "_pops"},  n_pops - p0, vecs[i].n);
    end

    // 256 distinct makes wrap the counter
    do_reset();
    s0 = n_strobes;
    for (int k = 0; k < 256; k++) push((k % 2 == 0) ? 8'h1C : 8'h32);
    drain(3 * 256 + 20);
    check("wrap_cnt", int'(press_cnt), 0);
    check("wrap_code", int'(key_code), 8'h32);
    check("wrap_strobes", n_strobes - s0, 256);

    // Async reset while in POP: byte is not popped and is decoded afterwards
    push(8'h1C);
    begin
      int c = 0;
      while (nextdata_n && c < 20) begin
        @(negedge clk);
        c++;
      end
    end
    check("pop_reached", int'(nextdata_n), 0);
    #1 rst = 1'b1;
    #1;
    check("async_nextdata_n", int'(nextdata_n), 1);
    check("async_key_valid", int'(key_valid), 0);
    check("async_key_code", int'(key_code), 0);
    check("async_press_cnt", int'(press_cnt), 0);
    @(negedge clk);
    rst = 1'b0;
    check("async_byte_kept", wr_ptr - rd_ptr, 1);
    drain(30);
    check("restart_code", int'(key_code), 8'h1C);
    check("restart_valid", int'(key_valid), 1);
    check("restart_cnt", int'(press_cnt), 1);

    // Randomized byte streams with random ready gaps
    for (int r = 0; r < 8; r++) begin
      int len;
      do_reset();
      model_reset();
      p0 = n_pops; s0 = n_strobes;
      len = int'($urandom_range(10, 40));
      for (int k = 0; k < len; k++) begin
        case ($urandom_range(0, 5))
          0: b = 8'hF0;
          1: b = 8'hE0;
          2: b = 8'h1C;
          3: b = 8'h32;
          4: b = 8'h75;
          default: b = 8'($urandom);
        endcase
        model_byte(b);
        push(b);
        repeat ($urandom_range(0, 4)) @(negedge clk);
      end
      drain(3 * len + 20);
      check($sformatf("rand%0d_code", r), int'(key_code), int'(m_code));
      check($sformatf("rand%0d_valid", r), int'(key_valid), int'(m_valid));
      check($sformatf("rand%0d_ext", r), int'(key_ext), int'(m_ext));
      check($sformatf("rand%0d_cnt", r), int'(press_cnt), int'(m_cnt));
      check($sformatf("rand%0d_strobes", r), n_strobes - s0, m_strobes);
      check($sformatf("rand%0d_pops", r), n_pops - p0, len);
    end

    check("nextdata_n_double_low", nd_dbl, 0);
    check("key_strobe_double_high", st_dbl, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ps2_key_ctrl.md
Name: ps2_key_ctrl

Overview:
Consumer-side sequencer for the PS/2 keyboard receive FIFO. It drains scan-code bytes through the FIFO's ready/nextdata_n handshake and parses make, break (0xF0) and extended (0xE0) prefixes. It publishes the currently held key, a one-cycle press strobe and a press counter. It sits between ps2_keyboard and the keycode_to_ascii/bcd7seg display path in top, replacing ad-hoc FIFO popping there.

Parameters:
CNT_W, 8, width of press_cnt; wraps modulo 2^CNT_W.

Ports:
clk  input  1  system clock; all state updates on posedge.
rst  input  1  asynchronous, active-high reset.
ready  input  1  FIFO non-empty flag from ps2_keyboard; data valid while high.
data  input  8  FIFO head byte from ps2_keyboard.
nextdata_n  output  1  active-low pop request to ps2_keyboard; low exactly one cycle per consumed byte.
key_code  output  8  scan code of the currently/last held key.
key_ext  output  1  1 if key_code was preceded by 0xE0 (see Optional Feature).
key_valid  output  1  high while a key is held (make seen, matching break not yet seen).
key_strobe  output  1  one-cycle pulse on each new (non-repeat) make.
press_cnt  output  CNT_W  count of new makes since reset.

Behaviour:
- Reset (async, rst=1): state=IDLE, nextdata_n=1, key_code=0, key_ext=0, key_valid=0, key_strobe=0, press_cnt=0, internal byte_r=0, brk_pend=0, ext_pend=0. Reset mid-byte abandons that byte; the FIFO is left unpopped unless nextdata_n was already low at the edge.
- FSM, all transitions on posedge clk:
  - IDLE: if ready, byte_r<=data, nextdata_n<=0, go POP. Else stay.
  - POP: nextdata_n<=1, go PROC. ready is ignored here, so the FIFO pointer can settle.
  - PROC: decode byte_r (below), go IDLE.
- Throughput: at most one byte per 3 cycles. nextdata_n is registered and is never low for two consecutive cycles.
- key_strobe defaults to 0 every cycle. It is set only in PROC on a new make and is visible the following cycle for exactly one cycle.
- Decode in PROC:
  - 0xF0: brk_pend<=1. No output change.
  - 0xE0: handled per Optional Feature.
  - Other byte b with brk_pend=1 (break):
    - If key_valid and b==key_code and ext_pend==key_ext, then key_valid<=0.
    - A break for any other key is ignored.
    - Clear brk_pend and ext_pend.
  - Other byte b with brk_pend=0 (make):
    - If key_valid and b==key_code and ext_pend==key_ext, it is a typematic repeat: no strobe, no count.
    - Otherwise key_code<=b, key_ext<=ext_pend, key_valid<=1, key_strobe<=1, press_cnt<=press_cnt+1 (wraps 2^CNT_W-1 -> 0).
    - Clear ext_pend.
- Back-to-back prefixes: a repeated 0xF0 keeps brk_pend=1. The sequence E0 F0 xx is a valid extended break.
- Rollover: a new make while another key is held replaces key_code; only the newest key is tracked.
- If ready drops while in IDLE, nothing happens. data is sampled only in IDLE with ready=1.

Optional Feature:
Macro PS2_KEY_EXT_EN.
- Defined: 0xE0 sets ext_pend<=1. key_ext follows the decode rules above. Extended and non-extended codes with the same byte are distinct keys.
- Undefined: 0xE0 is popped and discarded with no state change. ext_pend stays 0, and key_ext is tied to 0.

Test Plan:
1. Reset pulse, then FIFO bytes 1C, F0, 1C -> after the 1C make: key_code=0x1C, key_valid=1, one key_strobe pulse, press_cnt=1. After the F0 1C break: key_valid=0, press_cnt stays 1. nextdata_n pulses low 3 times, each exactly one cycle.
2. Typematic: 1C, 1C, 1C, F0, 1C -> exactly one key_strobe and press_cnt=1. key_valid clears only after the final 1C.
3. Rollover and stray break: 1C, 32, F0, 1C -> press_cnt=2, key_code=0x32, key_valid remains 1. Then F0, 32 -> key_valid=0.
4. With PS2_KEY_EXT_EN: E0, 75, F0, 75, E0, F0, 75 -> after E0 75: key_ext=1, key_code=0x75. The plain F0 75 break is ignored (key_valid=1). The E0 F0 75 break clears key_valid.
5. Without the macro: E0, 75 -> key_ext=0, key_code=0x75, press_cnt=1. Exactly two nextdata_n pulses.
6. Counter wrap and async reset: 256 distinct alternating makes (1C/32) with CNT_W=8 -> press_cnt returns to 0. Assert rst while the FSM is in POP -> all outputs are immediately reset values, nextdata_n=1, and decoding restarts cleanly on the next ready.
